// File: rtl/mem_access_unit.sv
// Load/store stage: one handshaked data-memory access per instruction,
// with lane formatting of load data, misalignment and timeout flags.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic        Stall,
   output logic [31:0] LoadData,
   output logic        AlignErr,
   output logic        BusErr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t      state;
   logic [CW-1:0] cnt;
   logic        req_r;
   logic [1:0]  lane_r;
   logic [1:0]  size_r;
   logic        sgn_r;

   logic        access;
   logic        misal;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [31:0] lane;
   logic [31:0] fmt;

   assign access = MemRead | MemWrite;

   always_comb begin
      misal = 1'b0;
      be_n  = 4'b0000;
      wd_n  = WriteData;
      unique case (MemSize)
         2'b00: begin
            be_n = 4'b0001 << Addr[1:0];
            wd_n = {4{WriteData[7:0]}};
         end
         2'b01: begin
            misal = Addr[0];
            be_n  = Addr[1] ? 4'b1100 : 4'b0011;
            wd_n  = {2{WriteData[15:0]}};
         end
         2'b10: begin
            misal = |Addr[1:0];
            be_n  = 4'b1111;
         end
         default: misal = 1'b1;
      endcase
   end

   assign lane = bus_rdata >> {lane_r, 3'b000};

   always_comb begin
      fmt = lane;
      unique case (size_r)
         2'b00: fmt = {{24{sgn_r & lane[7]}}, lane[7:0]};
         2'b01: fmt = {{16{sgn_r & lane[15]}}, lane[15:0]};
         default: fmt = lane;
      endcase
   end

   assign Stall    = ((state == IDLE) & access & ~misal)
                   | (state == REQ);
   assign AlignErr = (state == IDLE) & access & misal;
   // reset takes the request off the bus in the same cycle
   assign bus_req  = req_r & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_r     <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
         LoadData  <= '0;
         BusErr    <= 1'b0;
         lane_r    <= '0;
         size_r    <= '0;
         sgn_r     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (access && !misal) begin
                  state     <= REQ;
                  cnt       <= '0;
                  req_r     <= 1'b1;
                  bus_we    <= MemWrite;
                  bus_addr  <= {Addr[31:2], 2'b00};
                  bus_be    <= be_n;
                  bus_wdata <= wd_n;
                  lane_r    <= Addr[1:0];
                  size_r    <= MemSize;
                  sgn_r     <= MemSigned;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  req_r <= 1'b0;
                  if (!bus_we) LoadData <= fmt;
                  state <= DONE;
               end else if (cnt == TMAX) begin
                  req_r  <= 1'b0;
                  if (!bus_we) LoadData <= '0;
                  BusErr <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               BusErr <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store stage directly downstream of the ALU. It takes the ALU result as the effective address and the register-file B bus as store data. It runs one handshaked transaction on a word-wide data-memory bus with variable wait states, and stalls the CPU until the access retires. It returns byte-, half- or word-formatted, sign- or zero-extended load data to the write-back mux, and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: number of REQ cycles without `bus_ack` before the access is abandoned. Minimum value is 1.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store. If both MemRead and MemWrite are 1, the access is a store.
- MemSize  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- MemSigned  in  1  on loads, 1 sign-extends and 0 zero-extends.
- Addr  in  32  effective byte address (ALU result).
- WriteData  in  32  store data (RegBusB).
- Stall  out  1  combinational; holds the PC and register-file write.
- LoadData  out  32  registered, formatted load result.
- AlignErr  out  1  combinational misalignment flag.
- BusErr  out  1  registered timeout flag.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 for a write.
- bus_addr  out  32  word address: {Addr[31:2], 2'b00}.
- bus_be  out  4  byte enables; bit i selects bits [8i+7:8i].
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; valid only while bus_req=1.
- bus_rdata  in  32  read data; valid in the cycle bus_ack=1.

## Operation
- An access is pending when `access = MemRead | MemWrite`.
- An access is misaligned when any of these holds: MemSize=11; MemSize=01 and Addr[0]=1; MemSize=10 and Addr[1:0]≠00.
- State machine:
  - IDLE
    - If access and aligned: load the bus registers and go to REQ.
    - If access and misaligned: stay in IDLE. No bus activity.
    - If no access: stay in IDLE.
  - REQ
    - If bus_ack: capture the formatted bus_rdata into LoadData (loads only), clear bus_req, and go to DONE.
    - Else if the counter reaches TIMEOUT_CYCLES: clear bus_req, set LoadData=0 on loads, set BusErr=1, and go to DONE.
    - Else: increment the counter.
  - DONE
    - Lasts one cycle. Stall=0, so the instruction retires at the end of this cycle.
    - Inputs are ignored.
    - Next state is IDLE. BusErr clears on leaving DONE.
- Bus register values loaded on IDLE→REQ:
  - Byte: bus_be = 4'b0001 << Addr[1:0]; bus_wdata = {4{WriteData[7:0]}}.
  - Half: bus_be = Addr[1] ? 1100 : 0011; bus_wdata = {2{WriteData[15:0]}}.
  - Word: bus_be = 1111; bus_wdata = WriteData.
  - bus_we = MemWrite.
  - For loads, bus_be reflects the size. Memory may ignore bus_be on reads.
- Load formatting: select the lane `bus_rdata >> (8*Addr[1:0])` using Addr latched at IDLE→REQ. Take the low 8 or 16 bits, then extend per the latched MemSigned. Word loads pass through unchanged.
- Stores leave LoadData unchanged.
- `Stall = (IDLE & access & aligned) | REQ`.
- `AlignErr = IDLE & access & misaligned`. Stall is 0 when AlignErr=1, so the CPU handles the exception.

## Timing
- Reset values: state IDLE, counter 0, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, LoadData 0, BusErr 0. Stall and AlignErr are 0 while no access is presented.
- Reset mid-access: reset forces IDLE on the next edge and drops bus_req immediately. A late bus_ack after reset is ignored.
- Latency: an access presented in cycle 0 (IDLE) raises bus_req in cycle 1. With ack in cycle 1+k, DONE is cycle 2+k. Minimum is 3 cycles with Stall high for 2.
- Bus hold rule: bus_addr, bus_we, bus_be and bus_wdata stay stable for the whole time bus_req=1.
- bus_req is high for at most TIMEOUT_CYCLES+1 cycles.
- bus_ack while bus_req=0 has no effect.
- If bus_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins and BusErr stays 0.
- LoadData is valid from DONE onward and holds until the next completed load.
- Back-to-back accesses: the IDLE cycle following DONE samples the next instruction. There is no dead cycle beyond DONE.

## Test plan
- Word load, zero wait: Addr=0x100, MemSize=10, ack in the first REQ cycle with bus_rdata=0xDEADBEEF. Required: bus_addr=0x100, bus_be=1111, Stall high 2 cycles, LoadData=0xDEADBEEF in DONE.
- Signed byte load, 3 wait states: Addr=0x203, MemSigned=1, bus_rdata=0x80112233. Required: bus_be=1000, req held 4 cycles with stable addr, LoadData=0xFFFFFF80. Repeat with MemSigned=0: LoadData=0x00000080.
- Half store: Addr=0x12, WriteData=0x0000ABCD. Required: bus_we=1, bus_addr=0x10, bus_be=1100, bus_wdata=0xABCDABCD, and LoadData unchanged.
- Misaligned: word access at Addr=0x6 → AlignErr=1, Stall=0, bus_req stays 0. Also MemSize=11 at Addr=0 → AlignErr=1.
- Timeout: TIMEOUT_CYCLES=4, never ack. Required: bus_req high 5 cycles, then DONE with BusErr=1 and LoadData=0, then IDLE. Ack in the counter=4 cycle: normal completion, BusErr=0.
- Reset mid-access: assert reset in the second REQ cycle. Required: next cycle state IDLE with bus_req=0. A stray ack afterwards leaves LoadData=0.
